// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access width codes and the
// access legality check applied when a request is accepted.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } f3_e;

  localparam int MEM_BYTES_DEF = 4096;

  // True for an unknown width code or an address not aligned to the access size.
  function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] a_lsb);
    logic bad;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = a_lsb[0];
      F3_W:        bad = |a_lsb;
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Round-robin pick: the search starts at ptr_i and the first asserted request
// wins. Produces a one-hot grant plus the winner index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] winner_o,
  output logic          any_o
);

  logic [PW-1:0] idx;

  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between NUM_REQ requesters through a
// hold -> access -> respond pipeline; illegal accesses never reach the memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [3*NUM_REQ-1:0]      req_func3_i,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr_i,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_grant_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_error_o,
  output logic                      memoryReadEnable_o,
  output logic                      memoryWriteEnable_o,
  output logic [2:0]                func3_o,
  output logic [ADDR_W-1:0]         memoryAddress_o,
  output logic [DATA_W-1:0]         writeData_o,
  input  logic [DATA_W-1:0]         readData_i
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d, winner;
  logic [NUM_REQ-1:0] grant_raw;
  logic               any_req, accept;

  logic               sel_wr, sel_err;
  logic [2:0]         sel_f3;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  logic               hold_vld_q, hold_wr_q, hold_err_q;
  logic [2:0]         hold_f3_q;
  logic [ADDR_W-1:0]  hold_addr_q;
  logic [DATA_W-1:0]  hold_wdata_q;
  logic [PW-1:0]      hold_id_q;
  logic               mem_go;

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_error_q;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .grant_o  (grant_raw),
    .winner_o (winner),
    .any_o    (any_req)
  );

  // No acceptance while reset is held, so nothing enters the pipe mid-reset.
  assign req_grant_o = reset_i ? '0 : grant_raw;
  assign accept      = any_req & ~reset_i;

  always_comb begin
    sel_wr    = req_write_i[winner];
    sel_f3    = req_func3_i[3*int'(winner) +: 3];
    sel_addr  = req_addr_i[ADDR_W*int'(winner) +: ADDR_W];
    sel_wdata = req_wdata_i[DATA_W*int'(winner) +: DATA_W];
    sel_err   = access_bad(sel_f3, sel_addr[1:0]) | (sel_addr >= ADDR_W'(MEM_BYTES));
    rr_ptr_d  = rr_ptr_q;
    if (accept) rr_ptr_d = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rr_ptr_q     <= '0;
      hold_vld_q   <= 1'b0;
      hold_wr_q    <= 1'b0;
      hold_err_q   <= 1'b0;
      hold_f3_q    <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_id_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      hold_vld_q   <= accept;
      hold_wr_q    <= sel_wr;
      hold_err_q   <= sel_err;
      hold_f3_q    <= sel_f3;
      hold_addr_q  <= sel_addr;
      hold_wdata_q <= sel_wdata;
      hold_id_q    <= winner;
      rsp_valid_q  <= hold_vld_q ? (NUM_REQ'(1) << hold_id_q) : '0;
      rsp_error_q  <= hold_vld_q & hold_err_q;
      rsp_rdata_q  <= (mem_go & ~hold_wr_q) ? readData_i : '0;
    end
  end

  assign mem_go = hold_vld_q & ~hold_err_q & ~reset_i;

  assign memoryReadEnable_o  = mem_go & ~hold_wr_q;
  assign memoryWriteEnable_o = mem_go & hold_wr_q;
  assign func3_o             = mem_go ? hold_f3_q : '0;
  assign memoryAddress_o     = mem_go ? hold_addr_q : '0;
  assign writeData_o         = (mem_go & hold_wr_q) ? hold_wdata_q : '0;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, randomized traffic against a
// sequential memory model, and a reset-while-in-flight sequence.
module tb_dmem_arbiter;

  localparam int N  = 2;
  localparam int MB = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0, req_write = '0;
  logic [3*N-1:0] req_func3 = '0;
  logic [32*N-1:0] req_addr = '0, req_wdata = '0;
  logic [N-1:0]  req_grant, rsp_valid;
  logic [31:0]   rsp_rdata, memoryAddress, writeData, readData;
  logic          rsp_error, memoryReadEnable, memoryWriteEnable;
  logic [2:0]    func3;

  always #5 clock = ~clock;

  dmem_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32), .MEM_BYTES(MB)) dut (
    .clock_i(clock), .reset_i(reset),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_func3_i(req_func3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_grant_o(req_grant), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error),
    .memoryReadEnable_o(memoryReadEnable), .memoryWriteEnable_o(memoryWriteEnable),
    .func3_o(func3), .memoryAddress_o(memoryAddress), .writeData_o(writeData),
    .readData_i(readData)
  );

  // Memory image: word i holds i*512; it reloads that image whenever reset is high.
  function automatic logic [7:0] pat_byte(int i);
    logic [31:0] w;
    w = 32'(i / 4) * 32'd512;
    return w[8*(i%4) +: 8];
  endfunction

  logic [7:0]  mem [MB];
  logic [11:0] wa;
  assign wa = memoryAddress[11:0];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MB; i++) mem[i] <= pat_byte(i);
    end else if (memoryWriteEnable) begin
      mem[wa] <= writeData[7:0];
      if (func3[1:0] != 2'd0) mem[wa+12'd1] <= writeData[15:8];
      if (func3[1:0] == 2'd2) begin
        mem[wa+12'd2] <= writeData[23:16];
        mem[wa+12'd3] <= writeData[31:24];
      end
    end
  end

  always_comb begin
    logic [15:0] hw;
    readData = '0;
    hw = {mem[wa+12'd1], mem[wa]};
    case (func3[1:0])
      2'd0:    readData = {{24{mem[wa][7] & ~func3[2]}}, mem[wa]};
      2'd1:    readData = {{16{hw[15] & ~func3[2]}}, hw};
      default: readData = {mem[wa+12'd3], mem[wa+12'd2], hw};
    endcase
  end

  // Reference model: requests take effect in grant order on a plain byte array.
  typedef struct { int due; int owner; logic err; logic [31:0] data; } exp_t;
  exp_t        q[$];
  logic [7:0]  ref_mem [MB];
  int          ptr_m;
  int          cyc = 0, total = 0, bad = 0;

  task automatic ref_init();
    for (int i = 0; i < MB; i++) ref_mem[i] = pat_byte(i);
  endtask

  function automatic logic model_err(logic [2:0] f3, logic [31:0] a);
    if (a >= 32'd4096) return 1'b1;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (f3 == 3'd2 && a % 4 != 0) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    int nb;
    logic [31:0] v;
    nb = 1 << f3[1:0];
    v = '0;
    for (int b = 0; b < nb; b++) v = v | (32'(ref_mem[int'(a) + b]) << (8*b));
    if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    int nb;
    nb = 1 << f3[1:0];
    for (int b = 0; b < nb; b++) ref_mem[int'(a) + b] = d[8*b +: 8];
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic cyc_begin();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Compares one cycle against the model, then lets the model accept the winner.
  task automatic cyc_check();
    int win, idx;
    exp_t e;
    logic [2:0] f3;
    logic [31:0] a, d;
    #3;
    if (reset) begin
      chk("rst_grant", 32'(req_grant), 0);
      chk("rst_men", {30'd0, memoryReadEnable, memoryWriteEnable}, 0);
      chk("rst_addr", memoryAddress, 0);
      chk("rst_rsp", {rsp_error, 29'd0, rsp_valid}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      q.delete();
      ptr_m = 0;
      ref_init();
      return;
    end
    win = -1;
    for (int k = 0; k < N; k++) begin
      idx = (ptr_m + k) % N;
      if (win < 0 && req_valid[idx]) win = idx;
    end
    chk("grant", 32'(req_grant), (win >= 0) ? (32'd1 << win) : 32'd0);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.owner);
      chk("rsp_error", 32'(rsp_error), 32'(e.err));
      chk("rsp_rdata", rsp_rdata, e.data);
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 0);
    end
    if (memoryReadEnable || memoryWriteEnable) begin
      chk("mem_legal", {31'd0, model_err(func3, memoryAddress)}, 0);
      chk("mem_one_en", {31'd0, memoryReadEnable & memoryWriteEnable}, 0);
    end
    if (win >= 0) begin
      f3 = req_func3[3*win +: 3];
      a  = req_addr[32*win +: 32];
      d  = '0;
      e.err = model_err(f3, a);
      if (!e.err) begin
        if (req_write[win]) ref_store(f3, a, req_wdata[32*win +: 32]);
        else d = ref_load(f3, a);
      end
      q.push_back('{due: cyc + 2, owner: win, err: e.err, data: d});
      ptr_m = (win + 1) % N;
    end
  endtask

  // Requester protocol: a pending, ungranted request must be held unchanged.
  logic [N-1:0] hold_m = '0;
  logic [70:0]  snap [N];
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!reset && hold_m[i])
        assert (req_valid[i] && snap[i] == {req_write[i], req_func3[3*i +: 3], req_addr[32*i +: 32], req_wdata[32*i +: 32]})
          else $error("protocol: requester %0d altered a pending request", i);
      hold_m[i] <= req_valid[i] && !req_grant[i] && !reset;
      snap[i]   <= {req_write[i], req_func3[3*i +: 3], req_addr[32*i +: 32], req_wdata[32*i +: 32]};
    end
  end

  typedef struct {
    logic [1:0] v, w; logic [2:0] f0, f1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0] eg, ev; logic ee; logic [31:0] ed;
  } row_t;

  function automatic row_t mk(logic [1:0] v, logic [1:0] w, logic [2:0] f0, logic [2:0] f1,
                              logic [31:0] a0, logic [31:0] a1, logic [31:0] d0, logic [31:0] d1,
                              logic [1:0] eg, logic [1:0] ev, logic ee, logic [31:0] ed);
    row_t r;
    r.v = v; r.w = w; r.f0 = f0; r.f1 = f1; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
    r.eg = eg; r.ev = ev; r.ee = ee; r.ed = ed;
    return r;
  endfunction

  logic       pv [N], pw [N];
  logic [2:0] pf [N];
  logic [31:0] pa [N], pd [N];

  task automatic drive_pending();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pv[i];
      req_write[i] = pw[i];
      req_func3[3*i +: 3] = pf[i];
      req_addr[32*i +: 32] = pa[i];
      req_wdata[32*i +: 32] = pd[i];
    end
  endtask

  task automatic drive_idle();
    req_valid = '0; req_write = '0; req_func3 = '0; req_addr = '0; req_wdata = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t tbl[$];
    row_t r;
    int   r8, s, npend;

    tbl.push_back(mk(2'b01, 2'b00, 3'd2, 3'd0, 32'h40, 0, 0, 0, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 3'd2, 3'd2, 32'h44, 32'h48, 0, 0, 2'b10, 2'b01, 0, 32'd8192));
    tbl.push_back(mk(2'b11, 2'b00, 3'd2, 3'd2, 32'h44, 32'h48, 0, 0, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 3'd2, 3'd2, 32'h44, 32'h48, 0, 0, 2'b10, 2'b10, 0, 32'h2400));
    tbl.push_back(mk(2'b11, 2'b00, 3'd2, 3'd2, 32'h44, 32'h48, 0, 0, 2'b01, 2'b01, 0, 32'h2200));
    tbl.push_back(mk(2'b11, 2'b00, 3'd2, 3'd2, 32'h44, 32'h48, 0, 0, 2'b10, 2'b10, 0, 32'h2400));
    tbl.push_back(mk(2'b11, 2'b00, 3'd2, 3'd2, 32'h44, 32'h48, 0, 0, 2'b01, 2'b01, 0, 32'h2200));
    tbl.push_back(mk(2'b10, 2'b00, 3'd0, 3'd2, 0, 32'h48, 0, 0, 2'b10, 2'b10, 0, 32'h2400));
    tbl.push_back(mk(2'b10, 2'b10, 3'd0, 3'd2, 0, 32'h80, 0, 32'h12345678, 2'b10, 2'b01, 0, 32'h2200));
    tbl.push_back(mk(2'b01, 2'b00, 3'd1, 3'd0, 32'h80, 0, 0, 0, 2'b01, 2'b10, 0, 32'h2400));
    tbl.push_back(mk(2'b10, 2'b10, 3'd0, 3'd0, 0, 32'h84, 0, 32'h80, 2'b10, 2'b10, 0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 3'd0, 3'd0, 32'h84, 0, 0, 0, 2'b01, 2'b01, 0, 32'h00005678));
    tbl.push_back(mk(2'b01, 2'b00, 3'd2, 3'd0, 32'h42, 0, 0, 0, 2'b01, 2'b10, 0, 0));
    tbl.push_back(mk(2'b10, 2'b10, 3'd0, 3'd2, 0, 32'h1000, 0, 32'hDEADBEEF, 2'b10, 2'b01, 0, 32'hFFFFFF80));
    tbl.push_back(mk(2'b01, 2'b00, 3'd5, 3'd0, 32'h43, 0, 0, 0, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(2'b10, 2'b00, 3'd0, 3'd2, 0, 32'h80, 0, 0, 2'b10, 2'b10, 1, 0));
    tbl.push_back(mk(2'b01, 2'b00, 3'd3, 3'd0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 32'h12345678));
    tbl.push_back(mk(2'b01, 2'b00, 3'd2, 3'd0, 32'h0, 0, 0, 0, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(2'b01, 2'b00, 3'd2, 3'd0, 32'h4, 0, 0, 0, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 3'd2, 3'd0, 32'h8, 0, 0, 0, 2'b01, 2'b01, 0, 32'd0));
    tbl.push_back(mk(2'b01, 2'b00, 3'd2, 3'd0, 32'hC, 0, 0, 0, 2'b01, 2'b01, 0, 32'd512));
    tbl.push_back(mk(2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 32'd1024));
    tbl.push_back(mk(2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 32'd1536));
    tbl.push_back(mk(2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

    for (int i = 0; i < 3; i++) begin
      cyc_begin();
      cyc_check();
    end
    cyc_begin();
    reset = 1'b0;

    foreach (tbl[i]) begin
      if (i > 0) cyc_begin();
      r = tbl[i];
      req_valid = r.v; req_write = r.w; req_func3 = {r.f1, r.f0};
      req_addr = {r.a1, r.a0}; req_wdata = {r.d1, r.d0};
      cyc_check();
      chk($sformatf("tbl%0d_grant", i), 32'(req_grant), 32'(r.eg));
      chk($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(r.ev));
      if (r.ev != 2'b00) begin
        chk($sformatf("tbl%0d_rsp_error", i), 32'(rsp_error), 32'(r.ee));
        chk($sformatf("tbl%0d_rsp_rdata", i), rsp_rdata, r.ed);
      end
    end

    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    for (int c = 0; c < 340; c++) begin
      cyc_begin();
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && c < 300 && $urandom % 3 != 0) begin
          pv[i] = 1'b1;
          pw[i] = 1'($urandom % 2);
          pd[i] = $urandom;
          r8 = int'($urandom % 10);
          pf[i] = (r8 < 3) ? 3'd2 : (r8 < 5) ? 3'd0 : (r8 < 6) ? 3'd1 :
                  (r8 < 7) ? 3'd4 : (r8 < 8) ? 3'd5 : (r8 == 8) ? 3'($urandom_range(6, 7)) : 3'd3;
          s = int'($urandom % 16);
          pa[i] = (s == 0) ? 32'h1000 + ($urandom % 64) : (s == 1) ? 32'hFFFF_FFF0 : $urandom % 256;
        end
      end
      drive_pending();
      cyc_check();
      for (int i = 0; i < N; i++) if (req_grant[i]) pv[i] = 1'b0;
      npend = 0;
      for (int i = 0; i < N; i++) if (pv[i]) npend++;
      if (c >= 300 && npend == 0) break;
    end
    npend = 0;
    for (int i = 0; i < N; i++) if (pv[i]) npend++;
    if (npend != 0) begin
      total++; bad++;
      $display("FAIL drain cyc=%0d got=%0d pending want=0", cyc, npend);
    end

    for (int i = 0; i < 3; i++) begin
      cyc_begin();
      drive_idle();
      cyc_check();
    end
    cyc_begin();
    req_valid = 2'b10; req_write = 2'b10; req_func3 = {3'd2, 3'd0};
    req_addr = {32'h100, 32'h0}; req_wdata = {32'hA5A5A5A5, 32'h0};
    cyc_check();
    cyc_begin();
    drive_idle();
    reset = 1'b1;
    cyc_check();
    cyc_begin();
    cyc_check();
    cyc_begin();
    reset = 1'b0;
    req_valid = 2'b11; req_func3 = {3'd2, 3'd2}; req_addr = {32'h104, 32'h100};
    cyc_check();
    chk("post_rst_grant", 32'(req_grant), 32'd1);
    cyc_begin();
    req_valid = 2'b10;
    cyc_check();
    for (int i = 0; i < 3; i++) begin
      cyc_begin();
      drive_idle();
      cyc_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
